// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - single-car SCAN elevator controller with call latches, travel and door timers
module elevator_scan_ctrl #(
    parameter int N_FLOORS    = 10,
    parameter int FLOOR_W     = 4,
    parameter int TRAVEL_TIME = 2,
    parameter int DOOR_TIME   = 3,
    parameter int TIMER_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] hall_up,
    input  logic [N_FLOORS-1:0] hall_dn,
    input  logic [N_FLOORS-1:0] car_call,
    input  logic                door_hold,
    output logic [FLOOR_W-1:0]  floor_idx,
    output logic                moving_up,
    output logic                moving_dn,
    output logic                door_open,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pend_up,
    output logic [N_FLOORS-1:0] pend_dn,
    output logic [N_FLOORS-1:0] pend_car
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_t;

    localparam logic [TIMER_W-1:0]  T_TRAV = TIMER_W'(TRAVEL_TIME - 1);
    localparam logic [TIMER_W-1:0]  T_DOOR = TIMER_W'(DOOR_TIME - 1);
    localparam logic [TIMER_W-1:0]  T_ONE  = TIMER_W'(1);
    localparam logic [FLOOR_W-1:0]  F_ONE  = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0]  F_TOP  = FLOOR_W'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] UP_OK  = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_OK  = {{(N_FLOORS-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [N_FLOORS-1:0]   pu_q, pu_d, pd_q, pd_d, pc_q, pd_car_d;
    logic                  mu_q, md_q, do_q;

    logic [N_FLOORS-1:0]   p_up, p_dn, p_car, any_p;
    logic [N_FLOORS-1:0]   clr_up, clr_dn, clr_car;
    logic [N_FLOORS-1:0]   fbit, nbit;
    logic [FLOOR_W-1:0]    nxt;
    logic                  cur_above, cur_below, arr_above, arr_below;

    function automatic logic above_of(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        above_of = 1'b0;
        for (int k = 0; k < N_FLOORS; k++)
            if (v[k] && (k > int'(f))) above_of = 1'b1;
    endfunction

    function automatic logic below_of(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        below_of = 1'b0;
        for (int k = 0; k < N_FLOORS; k++)
            if (v[k] && (k < int'(f))) below_of = 1'b1;
    endfunction

    // Decisions see this cycle's presses; a same-cycle clear still wins.
    assign p_up     = pu_q | (hall_up & UP_OK);
    assign p_dn     = pd_q | (hall_dn & DN_OK);
    assign p_car    = pc_q | car_call;
    assign any_p    = p_up | p_dn | p_car;
    assign pu_d     = p_up & ~clr_up;
    assign pd_d     = p_dn & ~clr_dn;
    assign pd_car_d = p_car & ~clr_car;

    assign nxt       = (state_q == MOVE_UP) ? floor_q + F_ONE : floor_q - F_ONE;
    assign fbit      = N_FLOORS'(1) << floor_q;
    assign nbit      = N_FLOORS'(1) << nxt;
    assign cur_above = above_of(any_p, floor_q);
    assign cur_below = below_of(any_p, floor_q);
    assign arr_above = above_of(any_p, nxt);
    assign arr_below = below_of(any_p, nxt);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;
        case (state_q)
            IDLE: begin
                if (|(any_p & fbit)) begin
                    state_d = DOOR_OPEN;
                    timer_d = T_DOOR;
                    clr_up  = fbit;
                    clr_dn  = fbit;
                    clr_car = fbit;
                end else if (cur_above && cur_below) begin
                    state_d = dir_q ? MOVE_UP : MOVE_DN;
                    timer_d = T_TRAV;
                end else if (cur_above) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                    timer_d = T_TRAV;
                end else if (cur_below) begin
                    state_d = MOVE_DN;
                    dir_d   = 1'b0;
                    timer_d = T_TRAV;
                end
            end
            MOVE_UP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else begin
                    floor_d = nxt;
                    if (|((p_car | p_up | (arr_above ? '0 : p_dn)) & nbit) || nxt == F_TOP) begin
                        state_d = DOOR_OPEN;
                        timer_d = T_DOOR;
                        clr_car = nbit;
                        clr_up  = nbit;
                        if (!arr_above) begin
                            clr_dn = nbit;
                            dir_d  = 1'b0;
                        end
                    end else begin
                        timer_d = T_TRAV;
                    end
                end
            end
            MOVE_DN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else begin
                    floor_d = nxt;
                    if (|((p_car | p_dn | (arr_below ? '0 : p_up)) & nbit) || nxt == '0) begin
                        state_d = DOOR_OPEN;
                        timer_d = T_DOOR;
                        clr_car = nbit;
                        clr_dn  = nbit;
                        if (!arr_below) begin
                            clr_up = nbit;
                            dir_d  = 1'b1;
                        end
                    end else begin
                        timer_d = T_TRAV;
                    end
                end
            end
            DOOR_OPEN: begin
                // Presses matching the direction being served are absorbed while the door is open.
                clr_car = fbit;
                if (dir_q) clr_up = fbit;
                else       clr_dn = fbit;
                if (door_hold) begin
                    timer_d = T_DOOR;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (dir_q ? cur_above : cur_below) begin
                    state_d = dir_q ? MOVE_UP : MOVE_DN;
                    timer_d = T_TRAV;
                end else if (dir_q ? cur_below : cur_above) begin
                    state_d = dir_q ? MOVE_DN : MOVE_UP;
                    dir_d   = ~dir_q;
                    timer_d = T_TRAV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            timer_q <= '0;
            pu_q    <= '0;
            pd_q    <= '0;
            pc_q    <= '0;
            mu_q    <= 1'b0;
            md_q    <= 1'b0;
            do_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            pc_q    <= pd_car_d;
            mu_q    <= (state_d == MOVE_UP);
            md_q    <= (state_d == MOVE_DN);
            do_q    <= (state_d == DOOR_OPEN);
        end
    end

    assign floor_idx = floor_q;
    assign moving_up = mu_q;
    assign moving_dn = md_q;
    assign door_open = do_q;
    assign dir_up    = dir_q;
    assign pend_up   = pu_q;
    assign pend_dn   = pd_q;
    assign pend_car  = pc_q;

endmodule
